mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch (I) port and data (D) port.
- Sits between the IF/MEM stages and the backing memory, and replaces the separate instruction and data memories.
- Arbitrates by fixed priority (D over I) with an anti-starvation override, and runs a one-outstanding-transaction FSM.
- Produces per-port response pulses and stall signals for the hazard logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, number of consecutive D grants while I is pending before I is forced priority for one grant

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- i_req  input  1  fetch request; held high with i_addr stable until i_resp_valid or i_flush
- i_addr  input  ADDR_W  fetch address
- i_flush  input  1  cancels any pending/in-flight fetch (branch redirect)
- i_resp_valid  output  1  one-cycle pulse, i_rdata valid
- i_rdata  output  DATA_W  fetched word (registered)
- i_stall  output  1  i_req && !i_resp_valid
- d_req  input  1  data request; held with fields stable until d_resp_valid
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_resp_valid  output  1  one-cycle pulse on load data or store completion
- d_rdata  output  DATA_W  load data (registered; unchanged on store)
- d_stall  output  1  d_req && !d_resp_valid
- mem_req_valid  output  1  one-cycle command strobe to memory
- mem_we  output  1  write enable of the command
- mem_addr  output  ADDR_W  command address
- mem_wdata  output  DATA_W  command write data
- mem_resp_valid  input  1  memory completion pulse; earliest in the cycle after mem_req_valid
- mem_rdata  input  DATA_W  read data, valid with mem_resp_valid
- proto_err  output  1  sticky flag: mem_resp_valid seen outside a WAIT state

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, starve_cnt=0, flush_pend=0.
  - All outputs 0: mem_req_valid, mem_we, mem_addr, mem_wdata, i/d_resp_valid, i/d_rdata, proto_err.
  - Reset mid-transaction abandons it; no response pulse is generated afterwards.
- FSM states: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
- IDLE grant decision, evaluated on the edge:
  - If d_req && !(i_req && starve_cnt==STARVE_LIMIT): go to ISSUE_D, latch d_we/d_addr/d_wdata.
  - Else if i_req && !i_flush: go to ISSUE_I, latch i_addr, mem_we=0.
  - Else remain in IDLE.
- ISSUE_x: mem_req_valid=1 for exactly one cycle with the latched fields, then go to WAIT_x unconditionally.
- WAIT_x: on mem_resp_valid, register mem_rdata into x_rdata, pulse x_resp_valid next cycle, return to IDLE.
  - x_resp_valid coincides with IDLE, so the next grant is evaluated on that same edge. The requester must drop or update its req in that cycle.
- Minimum latency, zero-wait memory:
  - Request seen in cycle 0, ISSUE in cycle 1, mem_resp_valid in cycle 2, resp pulse in cycle 3.
  - Sustained throughput is one transaction per 3 cycles.
- starve_cnt:
  - Increments on each D grant while i_req is high, saturating at STARVE_LIMIT.
  - Clears on any I grant and whenever i_req is low in IDLE.
- Flush:
  - i_flush in ISSUE_I or WAIT_I sets flush_pend. The memory transaction still completes, but i_resp_valid is suppressed and i_rdata is not updated. flush_pend clears on return to IDLE.
  - i_flush in IDLE blocks an I grant that cycle.
  - i_flush has no effect on D transactions.
- Simultaneous i_req and d_req in IDLE: D wins unless the starvation override is active.
- Memory read data is always registered; outputs have no combinational path from mem_* to i/d_rdata.
- mem_resp_valid in IDLE or ISSUE_x: ignored for data, sets proto_err.
- Address and data are passed through unchanged; no alignment checks.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit enum: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D)
  - port-id constants PORT_I=0, PORT_D=1
  - default ADDR_W/DATA_W
- One natural sub-module, mem_arb_priority: pure combinational grant logic taking i_req, d_req, i_flush and starve_cnt, returning grant_i and grant_d. The FSM, starvation counter and registers stay in the top module.

Test Plan:
- Reset: hold reset=0 with i_req=1 -> all outputs 0 and mem_req_valid never asserts. Release reset -> mem_req_valid in cycle 1 with mem_addr=i_addr=0x0000_0000, i_resp_valid in cycle 3 with i_rdata=0x0000_0093.
- Conflict: i_req (0x10) and d_req load (0x100) asserted together in cycle 0 -> D is issued first (mem_addr=0x100, mem_we=0), d_rdata=0xDEADBEEF. I is issued at the edge of the d_resp_valid cycle, with mem_addr=0x10 in the following cycle.
- Starvation: d_req held continuously with stores and i_req held -> after 4 D grants the 5th grant goes to I. starve_cnt returns to 0 and D resumes after it.
- Flush: I in WAIT_I with a 5-cycle memory latency, i_flush pulsed -> mem response consumed, no i_resp_valid, i_rdata unchanged. The next i_req to 0x40 completes normally.
- Store: d_req d_we=1, addr 0x200, wdata 0x12345678 -> one mem_req_valid with mem_we=1 and the same addr/data; d_resp_valid pulses once; d_rdata unchanged.
- Protocol error and async reset: mem_resp_valid in IDLE -> proto_err=1 and sticky. Assert reset mid-WAIT_D -> immediate clear of all outputs and no d_resp_valid after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified I/D memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_I = 3'd1,
        ST_ISSUE_D = 3'd2,
        ST_WAIT_I  = 3'd3,
        ST_WAIT_D  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/mem_arb_priority.sv
// Combinational grant decision: D over I, unless I has been starved long enough.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic             i_flush,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_i_c,
    output logic             grant_d_c
);

    logic starve_hit;

    assign starve_hit = i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_d_c  = d_req && !starve_hit;
    // A fetch being redirected this cycle must not be issued.
    assign grant_i_c  = !grant_d_c && i_req && !i_flush;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between fetch (I) and data (D)
// ports with one outstanding transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_req_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              proto_err
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
    logic             flush_pend, flush_pend_nxt;
    logic             proto_err_nxt;
    logic             grant_i_c, grant_d_c;
    logic             load_i, load_d;
    logic             done;
    logic             i_done, d_done;
    logic             resp_port;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_priority (
        .i_req      (i_req),
        .d_req      (d_req),
        .i_flush    (i_flush),
        .starve_cnt (starve_cnt),
        .grant_i_c  (grant_i_c),
        .grant_d_c  (grant_d_c)
    );

    assign resp_port = (state == ST_WAIT_D) ? PORT_D : PORT_I;
    assign i_stall   = i_req && !i_resp_valid;
    assign d_stall   = d_req && !d_resp_valid;

    // Next-state, grant bookkeeping and completion decode.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        flush_pend_nxt = flush_pend;
        proto_err_nxt  = proto_err;
        load_i         = 1'b0;
        load_d         = 1'b0;
        done           = 1'b0;
        i_done         = 1'b0;
        d_done         = 1'b0;

        case (state)
            ST_IDLE: begin
                if (grant_d_c) begin
                    state_nxt = ST_ISSUE_D;
                    load_d    = 1'b1;
                end else if (grant_i_c) begin
                    state_nxt = ST_ISSUE_I;
                    load_i    = 1'b1;
                end
                if (!i_req || grant_i_c) begin
                    starve_cnt_nxt = '0;
                end else if (grant_d_c && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                    starve_cnt_nxt = starve_cnt + CNT_W'(1);
                end
            end
            ST_ISSUE_I: begin
                state_nxt = ST_WAIT_I;
                if (i_flush) flush_pend_nxt = 1'b1;
            end
            ST_ISSUE_D: begin
                state_nxt = ST_WAIT_D;
            end
            ST_WAIT_I, ST_WAIT_D: begin
                if ((state == ST_WAIT_I) && i_flush) flush_pend_nxt = 1'b1;
                if (mem_resp_valid) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A flush arriving with the response still cancels the fetch.
        i_done = done && (resp_port == PORT_I) && !(flush_pend || i_flush);
        d_done = done && (resp_port == PORT_D);

        if (state_nxt == ST_IDLE) flush_pend_nxt = 1'b0;
        if (mem_resp_valid && (state != ST_WAIT_I) && (state != ST_WAIT_D)) begin
            proto_err_nxt = 1'b1;
        end
    end

    // State, command and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            starve_cnt    <= '0;
            flush_pend    <= 1'b0;
            proto_err     <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            i_resp_valid  <= 1'b0;
            d_resp_valid  <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
        end else begin
            state         <= state_nxt;
            starve_cnt    <= starve_cnt_nxt;
            flush_pend    <= flush_pend_nxt;
            proto_err     <= proto_err_nxt;
            mem_req_valid <= load_i || load_d;
            if (load_d) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (load_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
            end
            i_resp_valid <= i_done;
            d_resp_valid <= d_done;
            if (i_done) i_rdata <= mem_rdata;
            // mem_we still holds the completed command's direction here.
            if (d_done && !mem_we) d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small latency-programmable memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_flush = 1'b0;
    logic        i_resp_valid;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_resp_valid;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_req_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        proto_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .proto_err(proto_err)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0093;
            32'h0000_0010: return 32'h0010_0113;
            32'h0000_0040: return 32'h00a0_0513;
            32'h0000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory model: responds mem_lat cycles after the strobe cycle.
    int unsigned mem_lat = 1;
    logic        mem_auto = 1'b1;
    logic [31:0] req_addr;
    always begin
        @(negedge clk);
        if (mem_auto && mem_req_valid === 1'b1) begin
            req_addr = mem_addr;
            repeat (mem_lat) @(negedge clk);
            mem_rdata      = mem_data(req_addr);
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
        end
    end

    task automatic test_reset();
        int seen = 0;
        reset = 1'b0; i_req = 1'b1; i_addr = 32'h0;
        repeat (4) begin
            @(negedge clk);
            if (mem_req_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL reset_no_req: got %0d strobes expected 0", seen); end
        checks++;
        if ({mem_req_valid, mem_we, mem_addr, mem_wdata, i_resp_valid, d_resp_valid, i_rdata, d_rdata, proto_err} !== '0) begin
            failures++; $display("FAIL reset_outputs: got req=%b we=%b addr=%h wd=%h ir=%b dr=%b id=%h dd=%h pe=%b expected all 0",
                mem_req_valid, mem_we, mem_addr, mem_wdata, i_resp_valid, d_resp_valid, i_rdata, d_rdata, proto_err);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_first_issue: got req=%b addr=%h we=%b expected 1 00000000 0", mem_req_valid, mem_addr, mem_we); end
        checks++; if (i_stall !== 1'b1) begin failures++; $display("FAIL reset_i_stall: got %b expected 1", i_stall); end
        repeat (2) @(negedge clk);
        checks++; if (i_resp_valid !== 1'b1 || i_rdata !== 32'h0000_0093) begin
            failures++; $display("FAIL reset_first_resp: got v=%b data=%h expected 1 00000093", i_resp_valid, i_rdata); end
        checks++; if (i_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_release: got %b expected 0", i_stall); end
        i_req = 1'b0;
        @(negedge clk);
        checks++; if (i_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_pulse: got %b expected 0", i_resp_valid); end
    endtask

    task automatic test_conflict();
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            failures++; $display("FAIL conflict_d_first: got req=%b addr=%h we=%b expected 1 00000100 0", mem_req_valid, mem_addr, mem_we); end
        repeat (2) @(negedge clk);
        checks++; if (d_resp_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || i_resp_valid !== 1'b0) begin
            failures++; $display("FAIL conflict_d_resp: got dv=%b data=%h iv=%b expected 1 deadbeef 0", d_resp_valid, d_rdata, i_resp_valid); end
        d_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h10) begin
            failures++; $display("FAIL conflict_i_second: got req=%b addr=%h expected 1 00000010", mem_req_valid, mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (i_resp_valid !== 1'b1 || i_rdata !== 32'h0010_0113) begin
            failures++; $display("FAIL conflict_i_resp: got v=%b data=%h expected 1 00100113", i_resp_valid, i_rdata); end
        i_req = 1'b0;
    endtask

    task automatic test_starvation();
        logic [9:0] seq = '0;
        int n = 0;
        int got_resp = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h1111_1111;
        i_req = 1'b1; i_addr = 32'h20;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (mem_req_valid === 1'b1) begin
                seq[n] = mem_we;
                n++;
            end
        end
        d_req = 1'b0;
        checks++; if (n != 10 || seq !== 10'b01111_01111) begin
            failures++; $display("FAIL starve_order: got n=%0d seq=%b expected 10 0111101111", n, seq); end
        for (int c = 0; c < 10 && got_resp == 0; c++) begin
            @(negedge clk);
            if (i_resp_valid === 1'b1) got_resp = 1;
        end
        i_req = 1'b0;
        checks++; if (got_resp != 1 || i_rdata !== 32'hA5A5_0020) begin
            failures++; $display("FAIL starve_i_resp: got seen=%0d data=%h expected 1 a5a50020", got_resp, i_rdata); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL starve_d_rdata: got %h expected deadbeef", d_rdata); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int iresp = 0;
        int mresp = 0;
        i_req = 1'b1; i_addr = 32'h30; i_flush = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin
            failures++; $display("FAIL flush_idle_block: got req=%b expected 0", mem_req_valid); end
        i_flush = 1'b0; mem_lat = 5;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h30) begin
            failures++; $display("FAIL flush_issue: got req=%b addr=%h expected 1 00000030", mem_req_valid, mem_addr); end
        @(negedge clk);
        i_flush = 1'b1; i_req = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (i_resp_valid === 1'b1) iresp++;
            if (mem_resp_valid === 1'b1) mresp++;
        end
        mem_lat = 1;
        checks++; if (iresp != 0 || mresp != 1) begin
            failures++; $display("FAIL flush_suppress: got iresp=%0d memresp=%0d expected 0 1", iresp, mresp); end
        checks++; if (i_rdata !== 32'hA5A5_0020 || proto_err !== 1'b0) begin
            failures++; $display("FAIL flush_rdata_kept: got data=%h pe=%b expected a5a50020 0", i_rdata, proto_err); end
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40) begin
            failures++; $display("FAIL flush_next_issue: got req=%b addr=%h expected 1 00000040", mem_req_valid, mem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (i_resp_valid !== 1'b1 || i_rdata !== 32'h00a0_0513) begin
            failures++; $display("FAIL flush_next_resp: got v=%b data=%h expected 1 00a00513", i_resp_valid, i_rdata); end
        i_req = 1'b0;
    endtask

    task automatic test_store();
        int reqs = 0;
        int dresp = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (mem_req_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin
                    failures++; $display("FAIL store_cmd: got req=%b we=%b addr=%h wd=%h expected 1 1 00000200 12345678",
                        mem_req_valid, mem_we, mem_addr, mem_wdata); end
            end
            if (mem_req_valid === 1'b1) reqs++;
            if (d_resp_valid === 1'b1) begin dresp++; d_req = 1'b0; end
        end
        checks++; if (reqs != 1 || dresp != 1) begin
            failures++; $display("FAIL store_pulses: got req=%0d resp=%0d expected 1 1", reqs, dresp); end
        checks++; if (d_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL store_rdata_kept: got %h expected deadbeef", d_rdata); end
    endtask

    task automatic test_proto_reset();
        int bad = 0;
        mem_auto = 1'b0;
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_clean: got %b expected 0", proto_err); end
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checks++; if (proto_err !== 1'b1 || d_resp_valid !== 1'b0 || i_resp_valid !== 1'b0) begin
            failures++; $display("FAIL proto_set: got pe=%b dv=%b iv=%b expected 1 0 0", proto_err, d_resp_valid, i_resp_valid); end
        repeat (2) @(negedge clk);
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_addr !== 32'h100) begin
            failures++; $display("FAIL areset_issue: got req=%b addr=%h expected 1 00000100", mem_req_valid, mem_addr); end
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_we, mem_addr, mem_wdata, i_resp_valid, d_resp_valid, i_rdata, d_rdata, proto_err} !== '0) begin
            failures++; $display("FAIL areset_clear: got req=%b we=%b addr=%h wd=%h ir=%b dr=%b id=%h dd=%h pe=%b expected all 0",
                mem_req_valid, mem_we, mem_addr, mem_wdata, i_resp_valid, d_resp_valid, i_rdata, d_rdata, proto_err);
        end
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0 || proto_err !== 1'b0) begin
            failures++; $display("FAIL areset_abandon: got bad_cycles=%0d pe=%b expected 0 0", bad, proto_err); end
        mem_auto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_starvation();
        test_flush();
        test_store();
        test_proto_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
